// File: rtl/prim_intr_coalesce.sv
// prim_intr_coalesce: per-source event coalescer (ports clk_i, rst_i, enable_i, threshold_i, timeout_i, flush_i, raw_event_i -> event_o, pending_o; timeout timer built when PRIM_INTR_COALESCE_TIMEOUT_EN is defined)
module prim_intr_coalesce #(
  parameter int Width  = 1,
  parameter int CntW   = 8,
  parameter int TimerW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [Width-1:0]  enable_i,
  input  logic [CntW-1:0]   threshold_i,
  input  logic [TimerW-1:0] timeout_i,
  input  logic              flush_i,
  input  logic [Width-1:0]  raw_event_i,
  output logic [Width-1:0]  event_o,
  output logic [Width-1:0]  pending_o
);
  typedef enum logic {IDLE, ACCUM} state_e;
  state_e          state_q [Width];
  state_e          state_d [Width];
  logic [CntW-1:0] cnt_q [Width];
  logic [CntW-1:0] cnt_d [Width];
  logic [Width-1:0] event_q, event_d;
  logic [CntW-1:0] thr_eff;
  assign thr_eff = |threshold_i ? threshold_i : CntW'(1);
`ifdef PRIM_INTR_COALESCE_TIMEOUT_EN
  logic [TimerW-1:0] timer_q [Width];
  logic [TimerW-1:0] timer_d [Width];
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
`endif
  for (genvar g = 0; g < Width; g++) begin : g_src
    logic [CntW-1:0] cnt_nx;
    logic            hit;
    logic            fire;
`ifdef PRIM_INTR_COALESCE_TIMEOUT_EN
    logic [TimerW:0] tnx;
    // timer counts from the batch's first event, so a batch lasts at most timeout_i cycles
    always_comb begin
      tnx        = {1'b0, timer_q[g]} + (TimerW+1)'(1);
      hit        = (state_q[g] == ACCUM) & |timeout_i & (tnx >= {1'b0, timeout_i});
      timer_d[g] = ~|cnt_d[g] ? '0 : (&timer_q[g] ? timer_q[g] : tnx[TimerW-1:0]);
    end
`else
    assign hit = 1'b0;
`endif
    always_comb begin
      cnt_nx     = &cnt_q[g] ? cnt_q[g] : cnt_q[g] + CntW'(raw_event_i[g]);
      fire       = enable_i[g] & ((cnt_nx >= thr_eff) | hit | (flush_i & |cnt_nx));
      cnt_d[g]   = (~enable_i[g] | fire) ? '0 : cnt_nx;
      state_d[g] = |cnt_d[g] ? ACCUM : IDLE;
      event_d[g] = fire;
    end
    assign pending_o[g] = (state_q[g] == ACCUM);
  end
  assign event_o = event_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_q <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= IDLE;
`ifdef PRIM_INTR_COALESCE_TIMEOUT_EN
        timer_q[i] <= '0;
`endif
      end
    end else begin
      event_q <= event_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
`ifdef PRIM_INTR_COALESCE_TIMEOUT_EN
        timer_q[i] <= timer_d[i];
`endif
      end
    end
  end
endmodule

// File: tb/tb_prim_intr_coalesce.sv
// tb_prim_intr_coalesce: table-driven, directed and randomized checks against a batch-level model
module tb_prim_intr_coalesce;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic [7:0]  thr;
  logic [15:0] to;
  logic        flush;
  logic [2:0]  raw;
  logic [2:0]  event_o, pending_o;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_cnt [3];
  int m_start [3];
  prim_intr_coalesce #(.Width(3), .CntW(8), .TimerW(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .threshold_i(thr), .timeout_i(to),
    .flush_i(flush), .raw_event_i(raw), .event_o(event_o), .pending_o(pending_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic [7:0] thr;
    logic       flush;
    logic [2:0] raw;
    logic [2:0] ev;
    logic [2:0] pd;
  } tv_t;
  tv_t tv [$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask
  // batch model: a batch is a count plus the cycle of its first event
  task automatic step();
    logic [2:0] xe = '0;
    logic [2:0] xp = '0;
    for (int i = 0; i < 3; i++) begin
      int cn, th, nc;
      bit hit, f;
      if (rst) begin
        m_cnt[i] = 0;
        continue;
      end
      cn  = m_cnt[i] + raw[i];
      if (cn > 255) cn = 255;
      th  = (thr == 0) ? 1 : thr;
      hit = 0;
`ifdef PRIM_INTR_COALESCE_TIMEOUT_EN
      hit = (m_cnt[i] != 0) && (to != 0) && ((cyc - m_start[i] + 1) >= to);
`endif
      f  = en[i] && (cn >= th || hit || (flush && cn != 0));
      nc = (!en[i] || f) ? 0 : cn;
      if (m_cnt[i] == 0 && nc != 0) m_start[i] = cyc;
      m_cnt[i] = nc;
      xe[i] = f;
      xp[i] = (nc != 0);
    end
    @(posedge clk);
    #1;
    chk("model_event", 32'(event_o), 32'(xe));
    chk("model_pending", 32'(pending_o), 32'(xp));
    cyc++;
  endtask
  task automatic apply(input logic r, input logic [2:0] e, input logic [7:0] t,
                       input logic f, input logic [2:0] w);
    rst = r; en = e; thr = t; flush = f; raw = w;
    step();
  endtask
  initial begin
    int npulse, at;
    rst = 1'b1; en = '0; thr = 8'd1; to = '0; flush = 1'b0; raw = '0;
    tv.push_back('{1, 7, 1, 0, 0, 0, 0});
    tv.push_back('{0, 7, 1, 0, 1, 1, 0});
    tv.push_back('{0, 7, 1, 0, 0, 0, 0});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 1, 0});
    tv.push_back('{0, 7, 4, 0, 0, 0, 0});
    tv.push_back('{0, 7, 8, 0, 1, 0, 1});
    tv.push_back('{0, 7, 8, 0, 1, 0, 1});
    tv.push_back('{0, 7, 8, 0, 1, 0, 1});
    tv.push_back('{0, 7, 8, 1, 0, 1, 0});
    tv.push_back('{0, 7, 8, 1, 0, 0, 0});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 6, 4, 0, 1, 0, 0});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 0, 1});
    tv.push_back('{0, 7, 4, 0, 1, 1, 0});
    tv.push_back('{0, 7, 2, 0, 1, 0, 1});
    tv.push_back('{0, 7, 2, 1, 1, 1, 0});
    tv.push_back('{0, 7, 2, 0, 0, 0, 0});
    tv.push_back('{0, 7, 8, 0, 1, 0, 1});
    tv.push_back('{0, 7, 8, 0, 1, 0, 1});
    tv.push_back('{0, 7, 8, 0, 1, 0, 1});
    tv.push_back('{0, 7, 2, 0, 0, 1, 0});
    tv.push_back('{0, 7, 2, 0, 0, 0, 0});
    tv.push_back('{0, 7, 0, 0, 1, 1, 0});
    tv.push_back('{0, 7, 2, 0, 1, 0, 1});
    tv.push_back('{0, 7, 2, 0, 1, 1, 0});
    tv.push_back('{0, 7, 2, 0, 1, 0, 1});
    tv.push_back('{0, 7, 2, 0, 1, 1, 0});
    tv.push_back('{0, 7, 2, 0, 0, 0, 0});
    tv.push_back('{0, 7, 2, 0, 7, 0, 7});
    tv.push_back('{0, 7, 2, 0, 2, 2, 5});
    tv.push_back('{0, 7, 2, 1, 0, 5, 0});
    for (int k = 0; k < tv.size(); k++) begin
      apply(tv[k].rst, tv[k].en, tv[k].thr, tv[k].flush, tv[k].raw);
      chk($sformatf("tv%0d_event", k), 32'(event_o), 32'(tv[k].ev));
      chk($sformatf("tv%0d_pending", k), 32'(pending_o), 32'(tv[k].pd));
    end
    // single event with timeout 20: pulse lands 20 cycles after the event only with the timer built
    apply(1, 0, 8, 0, 0);
    to = 16'd20;
    npulse = 0; at = -1;
    for (int k = 0; k < 26; k++) begin
      apply(0, 1, 8, 0, (k == 0) ? 3'd1 : 3'd0);
      if (event_o[0]) begin npulse++; at = k + 1; end
    end
`ifdef PRIM_INTR_COALESCE_TIMEOUT_EN
    chk("timeout_pulses", 32'(npulse), 32'd1);
    chk("timeout_cycle", 32'(at), 32'd20);
`else
    chk("notimer_pulses", 32'(npulse), 32'd0);
    chk("notimer_pending", 32'(pending_o[0]), 32'd1);
`endif
    apply(0, 1, 8, 1, 0);
    to = '0;
    // threshold 255 with raw held high for 300 cycles, then reset mid-batch
    apply(1, 0, 255, 0, 0);
    npulse = 0; at = -1;
    for (int k = 0; k < 300; k++) begin
      apply(0, 1, 255, 0, 1);
      if (event_o[0]) begin npulse++; at = k; end
    end
    chk("sat_pulses", 32'(npulse), 32'd1);
    chk("sat_pulse_at", 32'(at), 32'd254);
    chk("sat_new_batch", 32'(pending_o[0]), 32'd1);
    apply(1, 1, 255, 0, 1);
    chk("rst_event", 32'(event_o), 32'd0);
    chk("rst_pending", 32'(pending_o), 32'd0);
    to = 16'(5);
    thr = 8'(3);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) en[i] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) thr = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) to = 16'($urandom_range(0, 12));
      flush = ($urandom_range(0, 11) == 0);
      raw = 3'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
